// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
package mux_arb_pkg;

    localparam int N_REQ       = 4;
    localparam int SEL_W       = 2;
    localparam int DATA_W_DFLT = 8;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic logic [N_REQ-1:0] onehot4(input sel_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter4_if.sv
// Requester-side and consumer-side handshake bundle of the arbiter.
interface mux_rr_arbiter4_if
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
);
    logic [N_REQ-1:0]        in_valid;
    logic [N_REQ*DATA_W-1:0] in_data;
    logic [N_REQ-1:0]        in_ready;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    sel_t                    out_sel;
    logic                    out_ready;

    // Driver / consumer side (sources and downstream sink).
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    // Arbiter side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_rr_arbiter4_pick.sv
// Rotating priority search: first set request at or after ptr, wrapping 3->0.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             ptr,
    output logic             found,
    output sel_t             idx
);
    logic [2*N_REQ-1:0] dbl_s;
    logic [N_REQ-1:0]   rot_s;
    sel_t               off_s;

    // Rotate so that requester ptr lands at bit 0.
    assign dbl_s = {req, req} >> ptr;
    assign rot_s = dbl_s[N_REQ-1:0];

    // Fixed-priority search on the rotated vector, lowest bit wins.
    always_comb begin
        off_s = 2'd0;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
    end

    // Un-rotate: the 2-bit add wraps modulo 4.
    assign idx   = off_s + ptr;
    assign found = |req;
endmodule

// File: rtl/mux_rr_arbiter4.sv
// Round-robin arbiter feeding a 4:1 mux into a single-entry registered output stage.
module mux_rr_arbiter4
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
)(
    input  logic                clk,
    input  logic                rst,
    mux_rr_arbiter4_if.slave    bus,
    output logic [15:0]         grant_cnt
);
    logic              found_s;
    sel_t              win_s;
    logic              load_s;
    logic [N_REQ-1:0]  in_ready_s;
    logic [DATA_W-1:0] win_data_s;

    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    sel_t              out_sel_r;
    sel_t              ptr_r;
    logic [15:0]       grant_cnt_r;

    rr_pick4 u_pick (
        .req   (bus.in_valid),
        .ptr   (ptr_r),
        .found (found_s),
        .idx   (win_s)
    );

    // A slot is free when the output stage is empty or draining this edge.
    assign load_s     = ~rst & found_s & (~out_valid_r | bus.out_ready);
    assign win_data_s = bus.in_data[int'(win_s)*DATA_W +: DATA_W];

    // Grant strobe back to the winning requester only.
    always_comb begin
        in_ready_s = 4'b0000;
        if (load_s) begin
            in_ready_s = onehot4(win_s);
        end else begin
            in_ready_s = 4'b0000;
        end
    end

    // Output stage, priority pointer and transfer counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_sel_r   <= 2'd0;
            ptr_r       <= 2'd0;
            grant_cnt_r <= 16'd0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= win_data_s;
            out_sel_r   <= win_s;
            ptr_r       <= win_s + 2'd1;
            grant_cnt_r <= grant_cnt_r + 16'd1;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sel   = out_sel_r;
    assign grant_cnt     = grant_cnt_r;
endmodule

// File: tb/tb_mux_rr_arbiter4.sv
// Directed table-driven bench for mux_rr_arbiter4.
module tb_mux_rr_arbiter4;
    import mux_arb_pkg::*;

    typedef struct {
        logic        rst;
        logic [3:0]  vin;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  ir;
        logic        ov;
        logic [7:0]  od;
        logic [1:0]  os;
        logic [15:0] gc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] grant_cnt;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[$];

    localparam logic [31:0] DC = 32'h13121110;
    localparam logic [31:0] DA = 32'h00A50000;

    mux_rr_arbiter4_if bus ();

    mux_rr_arbiter4 dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] d, logic o,
                                logic [3:0] ir, logic ov, logic [7:0] od,
                                logic [1:0] os, logic [15:0] gc);
        vec_t t;
        t.rst = r; t.vin = v; t.data = d; t.ordy = o;
        t.ir = ir; t.ov = ov; t.od = od; t.os = os; t.gc = gc;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %h want %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        logic [1:0] s;
        logic [3:0] ir_seen;
        vec_t       pv;

        // Reset with everyone requesting, then first grant goes to requester 0.
        vecs.push_back(mk(1'b1, 4'hF, DC, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 16'd0));
        vecs.push_back(mk(1'b1, 4'hF, DC, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 16'd0));
        vecs.push_back(mk(1'b0, 4'hF, DC, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0, 16'd1));
        vecs.push_back(mk(1'b1, 4'hF, DC, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 16'd0));
        // Single requester, then drain.
        vecs.push_back(mk(1'b0, 4'h4, DA, 1'b1, 4'h4, 1'b1, 8'hA5, 2'd2, 16'd1));
        vecs.push_back(mk(1'b0, 4'h0, DC, 1'b1, 4'h0, 1'b0, 8'hA5, 2'd2, 16'd1));
        // Wrap-around pick from ptr=3.
        vecs.push_back(mk(1'b0, 4'h5, DC, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0, 16'd2));
        vecs.push_back(mk(1'b0, 4'h5, DC, 1'b1, 4'h4, 1'b1, 8'h12, 2'd2, 16'd3));
        vecs.push_back(mk(1'b0, 4'h5, DC, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0, 16'd4));
        vecs.push_back(mk(1'b0, 4'h8, DC, 1'b1, 4'h8, 1'b1, 8'h13, 2'd3, 16'd5));
        // Full contention from ptr=0, no bubbles.
        for (int k = 0; k < 8; k++) begin
            s = 2'(k % 4);
            vecs.push_back(mk(1'b0, 4'hF, DC, 1'b1, 4'b0001 << s, 1'b1,
                              8'h10 + {6'd0, s}, s, 16'(6 + k)));
        end
        // Backpressure for 5 cycles, then release loads requester 0 same edge.
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(mk(1'b0, 4'hF, DC, 1'b0, 4'h0, 1'b1, 8'h13, 2'd3, 16'd13));
        end
        vecs.push_back(mk(1'b0, 4'hF, DC, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0, 16'd14));
        // Run grant_cnt up to 37.
        for (int k = 0; k < 23; k++) begin
            s = 2'((1 + k) % 4);
            vecs.push_back(mk(1'b0, 4'hF, DC, 1'b1, 4'b0001 << s, 1'b1,
                              8'h10 + {6'd0, s}, s, 16'(15 + k)));
        end
        // Reset mid-operation, then a fresh grant.
        vecs.push_back(mk(1'b1, 4'hF, DC, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 16'd0));
        vecs.push_back(mk(1'b0, 4'hA, DC, 1'b1, 4'h2, 1'b1, 8'h11, 2'd1, 16'd1));
        vecs.push_back(mk(1'b0, 4'h0, DC, 1'b1, 4'h0, 1'b0, 8'h11, 2'd1, 16'd1));
        // Load into an empty stage with the sink stalled, then hold.
        vecs.push_back(mk(1'b0, 4'h2, DC, 1'b0, 4'h2, 1'b1, 8'h11, 2'd1, 16'd2));
        vecs.push_back(mk(1'b0, 4'h2, DC, 1'b0, 4'h0, 1'b1, 8'h11, 2'd1, 16'd2));

        rst           = 1'b1;
        bus.in_valid  = 4'h0;
        bus.in_data   = 32'h0;
        bus.out_ready = 1'b0;
        ir_seen       = 4'h0;
        pv            = vecs[0];
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            // Requesters left waiting must keep their data stable.
            if (i > 0 && !pv.rst) begin
                for (int r = 0; r < 4; r++) begin
                    if (pv.vin[r] && !ir_seen[r] && vecs[i].vin[r] &&
                        pv.data[r*8 +: 8] !== vecs[i].data[r*8 +: 8]) begin
                        errors++;
                        $display("FAIL proto vec %0d requester %0d data changed while waiting", i, r);
                    end
                end
            end
            rst           = vecs[i].rst;
            bus.in_valid  = vecs[i].vin;
            bus.in_data   = vecs[i].data;
            bus.out_ready = vecs[i].ordy;
            @(negedge clk);
            ir_seen = bus.in_ready;
            chk("in_ready", i, {12'd0, bus.in_ready}, {12'd0, vecs[i].ir});
            @(posedge clk);
            #1;
            chk("out_valid", i, {15'd0, bus.out_valid}, {15'd0, vecs[i].ov});
            chk("out_data",  i, {8'd0, bus.out_data},   {8'd0, vecs[i].od});
            chk("out_sel",   i, {14'd0, bus.out_sel},   {14'd0, vecs[i].os});
            chk("grant_cnt", i, grant_cnt,              vecs[i].gc);
            pv = vecs[i];
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_rr_arbiter4.md
Name: mux_rr_arbiter4

Overview:
- Round-robin arbiter that shares the 8-bit 4-to-1 mux datapath between four requesters.
- Each requester presents data with a valid/ready handshake. The block selects one winner per transfer, drives the mux select, and registers the muxed data into a single-entry output stage with its own valid/ready handshake.
- Sits between the four data sources and the shared downstream consumer.
- Sustains one transfer per cycle under continuous demand with no output stall.

Parameters:
- DATA_W, 8, width of each requester data word and of out_data.
- N_REQ, 4, number of requesters; fixed at 4, not user-overridable; SEL_W = 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  4  per-requester valid; bit i belongs to requester i.
- in_data  in  4*DATA_W  packed requester data; requester i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  4  one-hot or zero; bit i high means requester i's word is taken at this edge.
- out_valid  out  1  output register holds a word.
- out_data  out  DATA_W  registered muxed word.
- out_sel  out  2  index of the requester that supplied out_data.
- out_ready  in  1  downstream accepts out_data at this edge.
- grant_cnt  out  16  total completed input transfers since reset; wraps at 2^16.

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid=0, out_data=0, out_sel=0, grant_cnt=0, priority pointer ptr=0.
  - in_ready=0 while rst is high.
  - Any in-flight word is discarded.
- Priority pick (combinational):
  - Search in_valid starting at index ptr, ascending, wrapping 3->0.
  - The first set bit is the winner w; has_req = |in_valid.
- Load enable: load = has_req & (~out_valid | out_ready).
  - in_ready = load ? onehot(w) : 4'b0000.
  - in_ready may depend combinationally on in_valid and out_ready.
  - in_ready never depends combinationally on in_data.
- On a rising edge with load=1:
  - out_data <= in_data[w], out_sel <= w, out_valid <= 1.
  - ptr <= (w+1) mod 4.
  - grant_cnt <= grant_cnt+1.
- On an edge with load=0 and out_valid & out_ready: out_valid <= 0; out_data and out_sel hold their last values.
- On an edge with out_valid & ~out_ready: out_data, out_sel, out_valid and ptr all hold (backpressure).
- Latency: a word accepted at edge k appears on out_data after edge k, i.e. one cycle.
- Throughput: with out_ready held at 1, one transfer per cycle.
- States, with implicit encoding:
  - EMPTY (out_valid=0) -> FULL when load.
  - FULL -> FULL on (out_ready & has_req).
  - FULL -> EMPTY on (out_ready & ~has_req).
  - FULL stays FULL on ~out_ready.
- Fairness: a continuously requesting requester waits at most 3 grants before its own.
- ptr changes only on a load. A requester that drops in_valid without being granted loses no priority.
- Requester protocol: once in_valid is raised, in_data is held stable until in_ready is seen. The arbiter does not check this; the bench asserts it.
- grant_cnt wraps from 0xFFFF to 0x0000 silently.

Decomposition:
- Shared package mux_arb_pkg holds:
  - N_REQ=4, SEL_W=2, DATA_W default.
  - typedef sel_t (logic [1:0]).
- One combinational sub-module, rr_pick4:
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: found, idx[1:0].
  - Implemented with a rotate, fixed-priority search, and un-rotate.
- The top holds the output register, ptr, grant_cnt and the handshake logic.

Test Plan:
- Reset and idle: assert rst for 2 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_sel=0, out_data=0, grant_cnt=0 throughout. After release, the first grant goes to requester 0.
- Single requester: in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=8'hA5, out_sel=2; ptr=3; grant_cnt=1.
- Full contention: in_valid=4'b1111 for 8 cycles with out_ready=1 and data 8'h10+i -> out_sel sequence 0,1,2,3,0,1,2,3 and out_data 10,11,12,13,10,11,12,13, with no bubble cycles; grant_cnt=8.
- Wrap-around pick: drive to ptr=3, then in_valid=4'b0101 -> requester 0 is granted, then requester 2, then requester 0.
- Backpressure: out_valid=1 and out_ready=0 for 5 cycles with all requesters valid -> in_ready=0, and out_data and out_sel are stable. On the cycle out_ready=1, the next requester is loaded in the same edge.
- Reset mid-operation: assert rst while out_valid=1 and grant_cnt=37 -> after the edge out_valid=0, grant_cnt=0, ptr=0. The next grant with in_valid=4'b1010 goes to requester 1.
